// File: rtl/cpu_mem_pkg.sv
// Shared types for the memory port arbiter: requester/owner and FSM state encodings,
// default parameter values and grant/owner conversion helpers.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        OWN_DATA  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_IO    = 2'd2
    } owner_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int unsigned DEF_STARVE_LIMIT = 4;
    localparam int unsigned DEF_TIMEOUT      = 255;

    // Grant vectors are one-hot, bit index == owner encoding.
    function automatic owner_t gnt_to_owner(input logic [2:0] gnt);
        if (gnt[2])      return OWN_IO;
        else if (gnt[1]) return OWN_FETCH;
        else             return OWN_DATA;
    endfunction

    function automatic logic [2:0] owner_to_onehot(input owner_t own);
        return 3'b001 << own;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational priority picker: DATA > FETCH > IO, with IO jumping the queue when promoted.
module mem_arb_prio (
    input  logic [2:0] i_reqs,
    input  logic       i_io_promote,
    output logic [2:0] o_gnt
);

    always_comb begin
        o_gnt = '0;
        if (i_io_promote && i_reqs[2]) o_gnt = 3'b100;
        else if (i_reqs[0])            o_gnt = 3'b001;
        else if (i_reqs[1])            o_gnt = 3'b010;
        else if (i_reqs[2])            o_gnt = 3'b100;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between DATA, FETCH and IO; one transaction in flight,
// IO anti-starvation promotion and a mem_ready timeout that aborts with an error.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          d_gnt,
    output logic          f_gnt,
    output logic          io_gnt,
    output logic          d_done,
    output logic          f_done,
    output logic          io_done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          err_sticky,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_t        r_state, w_state_nxt;
    owner_t        r_owner;
    logic [TW-1:0] r_timer;
    logic [SW-1:0] r_starve;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [2:0]    r_gnt, r_done;
    logic          r_err, r_err_sticky;
    logic [DW-1:0] r_rdata;

    logic [2:0]    w_reqs, w_gnt;
    logic          w_promote, w_start, w_ready_done, w_timeout, w_finish;
    logic          w_cmd_we;
    logic [AW-1:0] w_cmd_addr;
    logic [DW-1:0] w_cmd_wdata;

    assign w_reqs    = {io_req, f_req, d_req};
    assign w_promote = (r_starve == STARVE_MAX);

    mem_arb_prio u_prio (
        .i_reqs       (w_reqs),
        .i_io_promote (w_promote),
        .o_gnt        (w_gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (|w_reqs) w_state_nxt = ST_BUSY;
            ST_BUSY: if (mem_ready || r_timer == TMO_LAST) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A mem_ready on the final allowed cycle completes normally rather than timing out.
    always_comb begin
        w_start      = (r_state == ST_IDLE) && (|w_reqs);
        w_ready_done = (r_state == ST_BUSY) && mem_ready;
        w_timeout    = (r_state == ST_BUSY) && !mem_ready && (r_timer == TMO_LAST);
        w_finish     = w_ready_done || w_timeout;
    end

    always_comb begin
        w_cmd_we    = 1'b0;
        w_cmd_addr  = f_addr;
        w_cmd_wdata = '0;
        case (gnt_to_owner(w_gnt))
            OWN_DATA: begin
                w_cmd_we    = d_we;
                w_cmd_addr  = d_addr;
                w_cmd_wdata = d_wdata;
            end
            OWN_IO: begin
                w_cmd_we    = io_we;
                w_cmd_addr  = io_addr;
                w_cmd_wdata = io_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= OWN_DATA;
            r_timer      <= '0;
            r_starve     <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_gnt        <= '0;
            r_done       <= '0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_gnt  <= w_start ? w_gnt : '0;
            r_done <= w_finish ? owner_to_onehot(r_owner) : '0;
            r_err  <= w_timeout;
            if (w_start) begin
                r_owner     <= gnt_to_owner(w_gnt);
                r_timer     <= '0;
                r_mem_we    <= w_cmd_we;
                r_mem_addr  <= w_cmd_addr;
                r_mem_wdata <= w_cmd_wdata;
                if (w_gnt[2])
                    r_starve <= '0;
                else if (io_req && r_starve != STARVE_MAX)
                    r_starve <= r_starve + SW'(1);
            end else if (r_state == ST_BUSY) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_finish)  r_rdata      <= (w_ready_done && !r_mem_we) ? mem_rdata : '0;
            if (w_timeout) r_err_sticky <= 1'b1;
        end
    end

    assign {io_gnt, f_gnt, d_gnt}    = r_gnt;
    assign {io_done, f_done, d_done} = r_done;
    assign rdata      = r_rdata;
    assign err        = r_err;
    assign err_sticky = r_err_sticky;
    assign mem_en     = (r_state == ST_BUSY);
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, all checked
// cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    import cpu_mem_pkg::*;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SL  = 4;
    localparam int unsigned TMO = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          d_req = 1'b0, d_we = 1'b0, f_req = 1'b0, io_req = 1'b0, io_we = 1'b0;
    logic [AW-1:0] d_addr = '0, f_addr = '0, io_addr = '0;
    logic [DW-1:0] d_wdata = '0, io_wdata = '0, mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          d_gnt, f_gnt, io_gnt, d_done, f_done, io_done;
    logic [DW-1:0] rdata, mem_wdata;
    logic          err, err_sticky, mem_en, mem_we;
    logic [AW-1:0] mem_addr;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference model: who owns the port, the command it latched, and expectations
    // for the cycle following each edge.
    bit            m_busy, m_we, m_sticky, e_err;
    int unsigned   m_owner, m_cycles, m_starve;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, e_rdata;
    logic [2:0]    e_gnt, e_done;
    int unsigned   s_others;
    bit            s_io_seen;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .f_req(f_req), .f_addr(f_addr),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .d_gnt(d_gnt), .f_gnt(f_gnt), .io_gnt(io_gnt),
        .d_done(d_done), .f_done(f_done), .io_done(io_done),
        .rdata(rdata), .err(err), .err_sticky(err_sticky),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_we = 0; m_sticky = 0; e_err = 0;
        m_owner = 0; m_cycles = 0; m_starve = 0;
        m_addr = '0; m_wdata = '0; e_rdata = '0; e_gnt = '0; e_done = '0;
    endtask

    // Applies the rules to the inputs present at the coming clock edge.
    task automatic model_edge();
        int w;
        e_gnt = '0; e_done = '0; e_err = 0;
        if (!m_busy) begin
            if (io_req && m_starve >= SL) w = 2;
            else if (d_req)               w = 0;
            else if (f_req)               w = 1;
            else if (io_req)              w = 2;
            else                          w = -1;
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_cycles = 0;
                case (w)
                    0:       begin m_we = d_we;  m_addr = d_addr;  m_wdata = d_wdata;  end
                    1:       begin m_we = 1'b0;  m_addr = f_addr;  m_wdata = '0;       end
                    default: begin m_we = io_we; m_addr = io_addr; m_wdata = io_wdata; end
                endcase
                if (w == 2) m_starve = 0;
                else if (io_req && m_starve < SL) m_starve++;
                e_gnt = 3'b001 << w;
            end
        end else begin
            m_cycles++;
            if (mem_ready) begin
                e_done = 3'b001 << m_owner;
                e_rdata = m_we ? '0 : mem_rdata;
                m_busy = 0;
            end else if (m_cycles == TMO) begin
                e_done = 3'b001 << m_owner;
                e_err = 1; e_rdata = '0; m_sticky = 1; m_busy = 0;
            end
        end
    endtask

    task automatic compare();
        check_eq("gnt", 64'({io_gnt, f_gnt, d_gnt}), 64'(e_gnt));
        check_eq("done", 64'({io_done, f_done, d_done}), 64'(e_done));
        check_eq("err", 64'(err), 64'(e_err));
        check_eq("err_sticky", 64'(err_sticky), 64'(m_sticky));
        check_eq("mem_en", 64'(mem_en), 64'(m_busy));
        if (m_busy) begin
            check_eq("mem_we", 64'(mem_we), 64'(m_we));
            check_eq("mem_addr", 64'(mem_addr), 64'(m_addr));
            if (m_we) check_eq("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        end
        if (|e_done) check_eq("rdata", 64'(rdata), 64'(e_rdata));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t, expected completion earlier", $time);
        $fatal(1, "bench time limit reached");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_pulses", 64'({d_gnt, f_gnt, io_gnt, d_done, f_done, io_done, err, err_sticky, mem_en, mem_we}), 64'(0));
        check_eq("reset_addr", 64'(mem_addr), 64'(0));
        check_eq("reset_rdata", 64'(rdata), 64'(0));
        rst = 1'b0;

        // Single FETCH read, ready in the first BUSY cycle.
        f_req = 1; f_addr = 32'h0000_0040; mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        check_eq("t1_f_gnt", 64'(f_gnt), 64'(1));
        f_req = 0;
        tick();
        check_eq("t1_f_done", 64'(f_done), 64'(1));
        check_eq("t1_rdata", 64'(rdata), 64'h0000_0000_DEAD_BEEF);

        // DATA write and FETCH together: DATA first.
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'd5; f_req = 1; f_addr = 32'h44;
        tick();
        check_eq("t2_d_gnt", 64'(d_gnt), 64'(1));
        check_eq("t2_mem_we", 64'(mem_we), 64'(1));
        check_eq("t2_mem_addr", 64'(mem_addr), 64'h100);
        d_req = 0;
        tick();
        tick();
        check_eq("t2_f_gnt", 64'(f_gnt), 64'(1));
        f_req = 0;
        tick();

        // IO starvation: DATA and FETCH requesting continuously.
        d_req = 1; d_we = 0; d_addr = 32'h200; f_req = 1; io_req = 1; io_we = 1;
        io_addr = 32'h300; io_wdata = 32'h77;
        for (int round = 0; round < 2; round++) begin
            s_others = 0; s_io_seen = 0;
            for (int c = 0; c < 30 && !s_io_seen; c++) begin
                tick();
                if (d_gnt || f_gnt) s_others++;
                if (io_gnt) s_io_seen = 1;
            end
            check_eq("starve_others", 64'(s_others), 64'(SL));
            check_eq("starve_io_gnt", 64'(s_io_seen), 64'(1));
        end
        d_req = 0; f_req = 0; io_req = 0;
        tick(); tick();

        // mem_ready on the last allowed BUSY cycle completes without error.
        mem_ready = 0; d_req = 1; d_we = 0; d_addr = 32'h400;
        tick();
        d_req = 0;
        repeat (TMO - 1) tick();
        mem_ready = 1; mem_rdata = 32'h1234_5678;
        tick();
        check_eq("limit_done", 64'(d_done), 64'(1));
        check_eq("limit_err", 64'(err), 64'(0));
        mem_ready = 0;

        // Timeout abort, then a late mem_ready is ignored.
        d_req = 1; d_addr = 32'h500;
        tick();
        d_req = 0;
        repeat (TMO) tick();
        check_eq("tmo_done", 64'(d_done), 64'(1));
        check_eq("tmo_err", 64'(err), 64'(1));
        check_eq("tmo_sticky", 64'(err_sticky), 64'(1));
        check_eq("tmo_mem_en", 64'(mem_en), 64'(0));
        mem_ready = 1;
        tick();
        check_eq("late_ready_done", 64'({io_done, f_done, d_done}), 64'(0));
        mem_ready = 0;
        tick();

        // Async reset in the middle of a BUSY transaction with FETCH waiting.
        d_req = 1; d_we = 1; d_addr = 32'h600; d_wdata = 32'h9; f_req = 1; f_addr = 32'h80;
        tick();
        d_req = 0;
        tick();
        #2 rst = 1;
        #1;
        check_eq("rst_mem_en", 64'(mem_en), 64'(0));
        check_eq("rst_pulses", 64'({d_gnt, f_gnt, io_gnt, d_done, f_done, io_done, err, err_sticky}), 64'(0));
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        tick();
        check_eq("rst_regrant", 64'(f_gnt), 64'(1));
        f_req = 0; mem_ready = 1;
        tick();
        mem_ready = 0;

        // Random traffic: requests held until granted, occasional withdrawal.
        for (int c = 0; c < 3000; c++) begin
            if (e_gnt[0]) d_req = 0;
            if (e_gnt[1]) f_req = 0;
            if (e_gnt[2]) io_req = 0;
            if (!d_req) begin
                if ($urandom_range(0, 99) < 30) begin
                    d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
                end
            end else if ($urandom_range(0, 99) < 3) d_req = 0;
            if (!f_req) begin
                if ($urandom_range(0, 99) < 30) begin
                    f_req = 1; f_addr = $urandom;
                end
            end else if ($urandom_range(0, 99) < 3) f_req = 0;
            if (!io_req) begin
                if ($urandom_range(0, 99) < 25) begin
                    io_req = 1; io_we = 1'($urandom_range(0, 1)); io_addr = $urandom; io_wdata = $urandom;
                end
            end else if ($urandom_range(0, 99) < 3) io_req = 0;
            mem_ready = ($urandom_range(0, 99) < 45);
            mem_rdata = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
